// File: rtl/vga_scan_driver.sv
// VGA raster generator: scan counters for the pixel core, sync/blank aligned to its latency.
// Optional colour-bar source enabled by `define VGA_SCAN_TESTPATTERN_EN (adds test_en).
module vga_scan_driver #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef VGA_SCAN_TESTPATTERN_EN
    input  logic       test_en,
`endif
    input  logic [5:0] pixel_in,
    output logic [9:0] pixel_col,
    output logic [8:0] pixel_row,
    output logic [1:0] vga_r,
    output logic [1:0] vga_g,
    output logic [1:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic       vblank_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

`ifdef VGA_SCAN_TESTPATTERN_EN
    localparam int unsigned DW = 6;
    localparam logic [DW-1:0] DLY_RST = 6'b000110;
`else
    localparam int unsigned DW = 3;
    localparam logic [DW-1:0] DLY_RST = 3'b110;
`endif

    logic [9:0]    r_h_cnt;
    logic [9:0]    r_v_cnt;
    logic [7:0]    r_frame_cnt;
    logic          w_line_end;
    logic          w_frame_end;
    logic          w_de_raw;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic [DW-1:0] w_raw;
    logic [DW-1:0] w_dly;
    logic [5:0]    w_rgb_src;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [5:0]    r_rgb;

    assign w_line_end  = (r_h_cnt == 10'(H_TOTAL - 1));
    assign w_frame_end = (r_v_cnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (w_line_end) begin
            r_h_cnt <= '0;
            if (w_frame_end) begin
                r_v_cnt     <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
                r_v_cnt <= r_v_cnt + 10'd1;
            end
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign w_de_raw = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    assign w_hs_raw = !((r_h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                        (r_h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs_raw = !((r_v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                        (r_v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));

    // Delay-line word: {[col bar index,] vs, hs, de}
`ifdef VGA_SCAN_TESTPATTERN_EN
    assign w_raw = {r_h_cnt[9:7], w_vs_raw, w_hs_raw, w_de_raw};
`else
    assign w_raw = {w_vs_raw, w_hs_raw, w_de_raw};
`endif

    generate
        if (PIPE_LAT == 0) begin : g_bypass
            assign w_dly = w_raw;
        end else begin : g_delay
            logic [DW-1:0] r_sr [PIPE_LAT];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < PIPE_LAT; i++) r_sr[i] <= DLY_RST;
                end else begin
                    r_sr[0] <= w_raw;
                    for (int unsigned i = 1; i < PIPE_LAT; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_dly = r_sr[PIPE_LAT-1];
        end
    endgenerate

`ifdef VGA_SCAN_TESTPATTERN_EN
    logic [2:0] w_bar;
    assign w_bar = w_dly[5:3];
    always_comb begin
        w_rgb_src = pixel_in;
        if (test_en) w_rgb_src = {w_bar[2], w_bar[2], w_bar[1], w_bar[1], w_bar[0], w_bar[0]};
    end
`else
    assign w_rgb_src = pixel_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_de    <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_dly[1];
            r_vsync <= w_dly[2];
            r_de    <= w_dly[0];
            r_rgb   <= w_dly[0] ? w_rgb_src : '0;
        end
    end

    assign pixel_col    = r_h_cnt;
    assign pixel_row    = r_v_cnt[8:0];
    assign frame_cnt    = r_frame_cnt;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign display_en   = r_de;
    assign vga_r        = r_rgb[5:4];
    assign vga_g        = r_rgb[3:2];
    assign vga_b        = r_rgb[1:0];
    // Gated by rst_n so a reset landing on the vblank position cannot strobe scene updates.
    assign vblank_start = rst_n && (r_h_cnt == '0) && (r_v_cnt == 10'(V_ACTIVE));

endmodule

// File: tb/tb_vga_scan_driver.sv
// Scoreboard bench for vga_scan_driver: three instances (PIPE_LAT 1/3/0) with shortened frames.
// Expected pin values are queued per cycle and popped PIPE_LAT+1 clocks later.
module tb_vga_scan_driver;

    localparam int ND  = 3;
    localparam int TAB = 32768;
    localparam int HA  [ND] = '{640, 6, 6};
    localparam int HFP [ND] = '{16, 1, 1};
    localparam int HSY [ND] = '{96, 2, 2};
    localparam int HBP [ND] = '{48, 1, 1};
    localparam int VA  [ND] = '{4, 3, 3};
    localparam int VFP [ND] = '{1, 1, 1};
    localparam int VSY [ND] = '{2, 1, 1};
    localparam int VBP [ND] = '{1, 1, 1};
    localparam int LAT [ND] = '{1, 3, 0};

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [5:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       test_en_a;
    logic [5:0] pix   [ND];
    logic [9:0] col_o [ND];
    logic [8:0] row_o [ND];
    logic [1:0] r_o   [ND];
    logic [1:0] g_o   [ND];
    logic [1:0] b_o   [ND];
    logic       hs_o  [ND];
    logic       vs_o  [ND];
    logic       de_o  [ND];
    logic       vb_o  [ND];
    logic [7:0] fc_o  [ND];

    exp_t       sbq [ND][$];
    int         mh [ND];
    int         mv [ND];
    int         mfc [ND];
    int         n;
    int         a_sw;
    int         prev_h0;
    logic       tp_on;
    logic [5:0] rnd_tab [TAB];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        vga_scan_driver #(
            .H_ACTIVE (HA[g]),
            .H_FP     (HFP[g]),
            .H_SYNC   (HSY[g]),
            .H_BP     (HBP[g]),
            .V_ACTIVE (VA[g]),
            .V_FP     (VFP[g]),
            .V_SYNC   (VSY[g]),
            .V_BP     (VBP[g]),
            .PIPE_LAT (LAT[g])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
`ifdef VGA_SCAN_TESTPATTERN_EN
            .test_en      ((g == 0) ? test_en_a : 1'b0),
`endif
            .pixel_in     (pix[g]),
            .pixel_col    (col_o[g]),
            .pixel_row    (row_o[g]),
            .vga_r        (r_o[g]),
            .vga_g        (g_o[g]),
            .vga_b        (b_o[g]),
            .hsync        (hs_o[g]),
            .vsync        (vs_o[g]),
            .display_en   (de_o[g]),
            .vblank_start (vb_o[g]),
            .frame_cnt    (fc_o[g])
        );
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [5:0] stim(input int d, input int nn, input int colprev);
        case (d)
            0:       return (nn >= a_sw) ? 6'h3F : 6'(colprev);
            1:       return rnd_tab[nn % TAB];
            default: return rnd_tab[nn % TAB] ^ 6'h2A;
        endcase
    endfunction

    function automatic exp_t model_exp(input int d, input int h, input int v,
                                       input logic [5:0] p, input logic tp);
        exp_t       e;
        logic [9:0] hc;
        logic [2:0] c;
        hc    = 10'(h);
        c     = hc[9:7];
        e.de  = (h < HA[d]) && (v < VA[d]);
        e.hs  = !((h >= HA[d] + HFP[d]) && (h < HA[d] + HFP[d] + HSY[d]));
        e.vs  = !((v >= VA[d] + VFP[d]) && (v < VA[d] + VFP[d] + VSY[d]));
        e.rgb = '0;
        if (e.de) e.rgb = tp ? {c[2], c[2], c[1], c[1], c[0], c[0]} : p;
        return e;
    endfunction

    task automatic reset_init();
        exp_t rst_e;
        rst_e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 6'd0};
        for (int d = 0; d < ND; d++) begin
            mh[d]  = 0;
            mv[d]  = 0;
            mfc[d] = 0;
            sbq[d].delete();
            for (int i = 0; i <= LAT[d]; i++) sbq[d].push_back(rst_e);
        end
        n       = 0;
        prev_h0 = 0;
    endtask

    task automatic hold_reset(input int ncyc);
        rst_n = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                check_val($sformatf("rst_hsync_d%0d", d), 32'(hs_o[d]), 32'd1);
                check_val($sformatf("rst_vsync_d%0d", d), 32'(vs_o[d]), 32'd1);
                check_val($sformatf("rst_de_d%0d", d), 32'(de_o[d]), 32'd0);
                check_val($sformatf("rst_rgb_d%0d", d), 32'({r_o[d], g_o[d], b_o[d]}), 32'd0);
                check_val($sformatf("rst_vblank_d%0d", d), 32'(vb_o[d]), 32'd0);
                check_val($sformatf("rst_col_d%0d", d), 32'(col_o[d]), 32'd0);
                check_val($sformatf("rst_frame_d%0d", d), 32'(fc_o[d]), 32'd0);
            end
        end
        rst_n = 1'b1;
        reset_init();
    endtask

    // One clock at its negedge: pop/compare pins, check counters, push next expectation, drive pixels.
    task automatic step_cycle();
        exp_t e;
        int   ht;
        int   vt;
        for (int d = 0; d < ND; d++) begin
            e = sbq[d].pop_front();
            check_val($sformatf("hsync_d%0d@%0d", d, n), 32'(hs_o[d]), 32'(e.hs));
            check_val($sformatf("vsync_d%0d@%0d", d, n), 32'(vs_o[d]), 32'(e.vs));
            check_val($sformatf("de_d%0d@%0d", d, n), 32'(de_o[d]), 32'(e.de));
            check_val($sformatf("rgb_d%0d@%0d", d, n), 32'({r_o[d], g_o[d], b_o[d]}), 32'(e.rgb));
            check_val($sformatf("col_d%0d@%0d", d, n), 32'(col_o[d]), 32'(mh[d]));
            check_val($sformatf("row_d%0d@%0d", d, n), 32'(row_o[d]), 32'(mv[d]));
            check_val($sformatf("frame_d%0d@%0d", d, n), 32'(fc_o[d]), 32'(mfc[d]));
            check_val($sformatf("vblank_d%0d@%0d", d, n), 32'(vb_o[d]),
                      32'((mh[d] == 0) && (mv[d] == VA[d])));
            sbq[d].push_back(model_exp(d, mh[d], mv[d], stim(d, n + LAT[d], mh[d]),
                                       (d == 0) && tp_on));
            pix[d] = stim(d, n, prev_h0);
        end
        prev_h0 = mh[0];
        for (int d = 0; d < ND; d++) begin
            ht = HA[d] + HFP[d] + HSY[d] + HBP[d];
            vt = VA[d] + VFP[d] + VSY[d] + VBP[d];
            mh[d]++;
            if (mh[d] == ht) begin
                mh[d] = 0;
                mv[d]++;
                if (mv[d] == vt) begin
                    mv[d]  = 0;
                    mfc[d] = (mfc[d] + 1) % 256;
                end
            end
        end
        n++;
        @(negedge clk);
    endtask

    initial begin
        int   hs_f1 = -1, hs_f2 = -1, hs_r1 = -1;
        int   vs_f1 = -1, vs_f2 = -1, vs_r1 = -1;
        int   de_cnt = 0, f3_cnt = 0, vb_cnt = 0, vb_first = -1;
        int   k;
        logic prev_hs = 1'b1;
        logic prev_vs = 1'b1;

        for (int i = 0; i < TAB; i++) rnd_tab[i] = 6'($urandom);
        a_sw      = 6400;
        tp_on     = 1'b0;
        test_en_a = 1'b0;
        for (int d = 0; d < ND; d++) pix[d] = '0;

        hold_reset(3);

        // Two full frames of instance 0, second one with constant white input.
        for (int i = 0; i < 15370; i++) begin
            if (hs_o[0] === 1'b0 && prev_hs) begin
                if (hs_f1 < 0) hs_f1 = n; else if (hs_f2 < 0) hs_f2 = n;
            end
            if (hs_o[0] === 1'b1 && !prev_hs && hs_f1 >= 0 && hs_r1 < 0) hs_r1 = n;
            if (vs_o[0] === 1'b0 && prev_vs) begin
                if (vs_f1 < 0) vs_f1 = n; else if (vs_f2 < 0) vs_f2 = n;
            end
            if (vs_o[0] === 1'b1 && !prev_vs && vs_f1 >= 0 && vs_r1 < 0) vs_r1 = n;
            if (n >= 6402 && n < 12802) begin
                if (de_o[0]) de_cnt++;
                if ({r_o[0], g_o[0], b_o[0]} == 6'h3F) f3_cnt++;
            end
            if (n < 12800 && vb_o[0]) begin
                vb_cnt++;
                if (vb_first < 0) vb_first = n;
            end
            if (n == 12800) check_val("a_frames_after_2", 32'(fc_o[0]), 32'd2);
            if (n == 15359) check_val("b_frame_255", 32'(fc_o[1]), 32'd255);
            if (n == 15360) check_val("b_frame_wrap", 32'(fc_o[1]), 32'd0);
            prev_hs = hs_o[0];
            prev_vs = vs_o[0];
            step_cycle();
        end

        check_val("hs_first_fall", 32'(hs_f1), 32'd658);
        check_val("hs_width", 32'(hs_r1 - hs_f1), 32'd96);
        check_val("line_period", 32'(hs_f2 - hs_f1), 32'd800);
        check_val("vs_first_fall", 32'(vs_f1), 32'd4002);
        check_val("vs_width", 32'(vs_r1 - vs_f1), 32'd1600);
        check_val("frame_period", 32'(vs_f2 - vs_f1), 32'd6400);
        check_val("de_per_frame", 32'(de_cnt), 32'd2560);
        check_val("white_per_frame", 32'(f3_cnt), 32'd2560);
        check_val("vblank_pulses", 32'(vb_cnt), 32'd2);
        check_val("vblank_first", 32'(vb_first), 32'd3200);

        // Run to mid-line of an active row on instance 0, then reset.
        k = 0;
        while (!(mh[0] == 300 && mv[0] == 2) && k < 7000) begin
            step_cycle();
            k++;
        end
        check_val("mid_reached", 32'(k < 7000), 32'd1);
        check_val("mid_col", 32'(col_o[0]), 32'd300);
        check_val("mid_row", 32'(row_o[0]), 32'd2);
        a_sw      = 1 << 30;
`ifdef VGA_SCAN_TESTPATTERN_EN
        tp_on     = 1'b1;
        test_en_a = 1'b1;
`endif
        hold_reset(3);

        for (int i = 0; i < 2000; i++) begin
`ifdef VGA_SCAN_TESTPATTERN_EN
            if (n == 130) check_val("bar1", 32'({r_o[0], g_o[0], b_o[0]}), 32'h03);
            if (n == 258) check_val("bar2", 32'({r_o[0], g_o[0], b_o[0]}), 32'h0C);
`endif
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
Name: vga_scan_driver

Overview:
- Display-side counterpart of the pixel core: generates the raster scan (pixel_col/pixel_row) that the pixel core consumes.
- Accepts the core's registered 6-bit rrggbb colour and drives VGA hsync/vsync/RGB.
- Delays sync and blanking to match the pixel core's pipeline latency.
- Emits a vertical-blank strobe that tells scene registers when they may safely update polygon data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_LAT, 1, clocks from pixel_col/row to valid pixel_in; legal 0..4

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  synchronous, active-low reset
- pixel_in  in  6  rrggbb colour from pixel core
- pixel_col  out  10  horizontal counter h_cnt, 0..H_TOTAL-1
- pixel_row  out  9  vertical counter v_cnt[8:0]; meaningful only while v_cnt < V_ACTIVE
- vga_r  out  2  red, zero when blanked
- vga_g  out  2  green, zero when blanked
- vga_b  out  2  blue, zero when blanked
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- display_en  out  1  high when the presented RGB is visible
- vblank_start  out  1  one-clock strobe at the start of vertical blank (undelayed)
- frame_cnt  out  8  completed-frame counter, wraps

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - v_cnt is 10 bits internally.
- Counters:
  - h_cnt increments every clk.
  - At h_cnt == H_TOTAL-1: h_cnt wraps to 0 and v_cnt increments.
  - At v_cnt == V_TOTAL-1 on that same clock: v_cnt wraps to 0 and frame_cnt increments (255 -> 0).
- pixel_col / pixel_row are driven directly from the counters (no delay).
- Raw timing decoded from the counters:
  - de_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment:
  - de_raw, hs_raw and vs_raw pass through a PIPE_LAT-deep shift register.
  - The delayed values are then registered once more alongside pixel_in.
  - Total latency from counter value to hsync/vsync/display_en/RGB pins = PIPE_LAT+1 clocks.
  - PIPE_LAT=0: delay line is bypassed; only the output register remains.
- RGB:
  - Output register loads pixel_in when delayed de is 1, else 6'b000000.
  - Mapping: vga_r = [5:4], vga_g = [3:2], vga_b = [1:0].
- vblank_start:
  - Combinational decode, high exactly when h_cnt == 0 && v_cnt == V_ACTIVE.
  - One pulse per frame, not delayed.
- Reset (synchronous, rst_n low at posedge):
  - h_cnt = 0, v_cnt = 0, frame_cnt = 0.
  - All delay stages cleared to de=0, hs=1, vs=1.
  - Outputs: hsync=1, vsync=1, display_en=0, RGB=0.
  - Reset mid-frame aborts the frame immediately; no partial sync pulse is extended.
  - First active pixel appears PIPE_LAT+1 clocks after the first clock with rst_n high.
- Simultaneous events:
  - Line wrap and frame wrap on the same clock both take effect; v_cnt goes to 0, not V_TOTAL.
- pixel_in is ignored while delayed de is 0; X on pixel_in during blank must not reach the pins.

Optional Feature:
- Macro: VGA_SCAN_TESTPATTERN_EN.
- Defined:
  - Adds input test_en (1 bit).
  - When test_en=1, the RGB register source is replaced by 8 vertical colour bars: colour = {c[2],c[2],c[1],c[1],c[0],c[0]}, where c = delayed pixel_col[9:7].
  - Delayed pixel_col is carried through the same PIPE_LAT delay line.
  - Sync and display_en timing are unchanged.
- Undefined: no test_en port, no extra delay stage; RGB is always pixel_in.

Test Plan:
- Reset then run 2 frames, PIPE_LAT=1 → hsync low for exactly 96 clks starting 658 clks after the line's h_cnt=0; vsync low for 2 lines; line period 800 clks; frame period 420000 clks; frame_cnt=2.
- Drive pixel_in = pixel_col[5:0] through a 1-clk register, PIPE_LAT=1 → at every display_en=1 cycle, {vga_r,vga_g,vga_b} equals the col value sampled 2 clks earlier; RGB=0 whenever display_en=0.
- Force pixel_in=6'h3F constantly → RGB=0 throughout h_cnt 640..799 and lines 480..524 (delay-adjusted); display_en high count per frame = 307200.
- Check vblank_start → exactly one pulse per frame, coincident with pixel_col=0 / v_cnt=480; absent during reset.
- Assert rst_n low for 3 clks mid-line (h_cnt=300, v_cnt=200) → hsync=1, vsync=1, RGB=0 next clk; after release pixel_col=0,1,2… from 0; frame_cnt=0.
- Rebuild with PIPE_LAT=3 and VGA_SCAN_TESTPATTERN_EN, test_en=1 → display_en delayed by 4 clks vs de_raw; bar colours step 000000, 000011, 001100 … 111111 every 128 pixels.
